cmos_nvram_bridge: RTL and testbench
====================================

# cmos_nvram_bridge

Bridges the Turkey Shoot 1K×4 CMOS (high-score/settings) RAM to the HPS ioctl channel. It sits in the emu top level beside the ROM download path and is its read-back counterpart. On an HPS upload it reads the CMOS nibbles out as bytes. On an HPS download of the NVRAM index it restores them. After the game CPU has modified CMOS it requests an autosave.

## Interface
Parameters:
- NV_INDEX, 16'd4: ioctl_index value that selects NVRAM traffic.
- RAM_DEPTH, 1024: number of CMOS nibbles; addresses ≥ RAM_DEPTH are out of range.
- AUTOSAVE_TICKS, 8'd250: number of quiet cnt_4ms periods before an autosave request (250 ≈ 1 s).

Ports:
- clock_12 in 1: the single clock.
- reset in 1: synchronous, active-high.
- ioctl_upload in 1: HPS upload window.
- ioctl_download in 1: HPS download window.
- ioctl_index in 16: selects the transfer target.
- ioctl_addr in 25: byte address of the transfer.
- ioctl_rd in 1: one-cycle read strobe.
- ioctl_wr in 1: one-cycle write strobe.
- ioctl_dout in 8: download data.
- ioctl_din out 8: upload data.
- ioctl_upload_req out 1: one-cycle autosave request pulse.
- ram_addr out 10: address on the bridge-owned second port of the CMOS RAM.
- ram_wdata out 4: write nibble.
- ram_we out 1: write strobe.
- ram_rdata in 4: read nibble, synchronous with 1-cycle latency.
- cpu_cmos_we in 1: write strobe from the CPU-side CMOS port.
- cnt_4ms in 1: 4 ms timebase from williams2.
- busy out 1: high when the FSM is not in IDLE or a matching upload/download window is open.

## Operation
- Match condition: `ioctl_index == NV_INDEX`. Strobes are ignored when the index does not match.
- FSM states:
  - IDLE:
    - matched ioctl_rd with ioctl_upload → RD_ADDR.
    - matched ioctl_wr with ioctl_download → WR.
  - RD_ADDR: drive ram_addr = ioctl_addr[9:0] → RD_DATA.
  - RD_DATA:
    - ioctl_din ← {4'h0, ram_rdata}.
    - If the address is out of range, ioctl_din ← 8'h00 instead, and no RAM read is needed.
    - → IDLE.
  - WR:
    - For an in-range address, assert ram_we for exactly one cycle with ram_addr = ioctl_addr[9:0] and ram_wdata = ioctl_dout[3:0]. ioctl_dout[7:4] is ignored.
    - For an out-range address, make no write.
    - → IDLE.
- Simultaneous rd and wr: upload wins and wr is dropped.
  - A strobe arriving while the FSM is not in IDLE is dropped. The HPS strobe spacing of ≥ 4 cycles guarantees this does not occur in normal use.
- Autosave:
  - The dirty flag is set by cpu_cmos_we, except while a matched download window is open.
  - Quiet counter:
    - Cleared on every cpu_cmos_we.
    - Increments on each cnt_4ms rising edge while dirty is set.
    - Saturates at AUTOSAVE_TICKS.
  - Reaching AUTOSAVE_TICKS with dirty set and no upload/download active:
    - pulse ioctl_upload_req for 1 cycle;
    - set the pending flag, which blocks re-requests.
  - Falling edge of a matched ioctl_upload clears dirty, pending and the counter.
  - A download end clears dirty, because the restored contents count as clean.

## Timing
- Reset values:
  - ioctl_din = 8'h00, ram_we = 0, ram_addr = 0, ram_wdata = 0;
  - ioctl_upload_req = 0, busy = 0;
  - dirty, pending and counter = 0; FSM = IDLE.
- Upload: rd at cycle N → ram_addr valid at N+1 → ioctl_din valid at N+2. ioctl_din holds until the next accepted rd.
- Download: wr at cycle N → ram_we high during N+1 only.
- cnt_4ms is edge-detected with a 1-cycle registered copy. The counter width is 8 bits.
- Reset mid-operation: the FSM returns to IDLE in the next cycle, and no partial write occurs. ram_we is combinationally qualified by state WR.

## Structure
- Shared package, williams2_pkg:
  - NV_INDEX default;
  - CMOS_AW = 10 and CMOS_DW = 4;
  - the FSM state enum {IDLE, RD_ADDR, RD_DATA, WR}.
- Sub-module nv_autosave_timer: dirty/pending/counter logic plus cnt_4ms edge detect. Its outputs are ioctl_upload_req and dirty. The FSM stays in the top module.

## Test plan
- Upload read: preload RAM[0x123] = 4'hA; with upload matched, pulse rd at ioctl_addr = 0x123 → ioctl_din = 8'h0A two cycles later, held until the next rd.
- Download write: wr with ioctl_addr = 0x3FF and ioctl_dout = 8'h5C → ram_we for one cycle, ram_addr = 0x3FF, ram_wdata = 4'hC.
- Out of range: rd at 0x400 → ioctl_din = 8'h00; wr at 0x400 → ram_we stays 0.
- Index mismatch: ioctl_index = 0 with rd/wr strobes → no ram_we, ioctl_din unchanged, busy = 0.
- Autosave: one cpu_cmos_we, then AUTOSAVE_TICKS = 3 cnt_4ms edges → exactly one ioctl_upload_req pulse.
  - A second cpu_cmos_we before the 3rd edge restarts the count.
  - Ending the upload clears pending.
- Reset mid-operation: assert reset in the WR cycle → ram_we = 0 that cycle, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/williams2_pkg.sv
// Shared Williams-2 definitions used by the CMOS/NVRAM bridge.
package williams2_pkg;

  // ioctl_index value selecting NVRAM traffic
  localparam logic [15:0] NV_INDEX_DEF = 16'd4;

  // CMOS RAM geometry: 1K x 4
  localparam int CMOS_AW = 10;
  localparam int CMOS_DW = 4;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } nv_state_t;

  // True when a byte address falls inside the CMOS array
  function automatic logic nv_in_range(input logic [24:0] addr, input logic [24:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/nv_autosave_timer.sv
// Autosave request generator: tracks CPU writes to CMOS (dirty), waits for a
// quiet period measured in cnt_4ms periods and then issues a single upload
// request. pending blocks further requests until the HPS upload finishes.
module nv_autosave_timer #(
  parameter logic [7:0] TICKS = 8'd250
) (
  input  logic clock_12,
  input  logic reset,
  input  logic cnt_4ms,
  input  logic cpu_cmos_we,
  input  logic upload_win,    // matched upload window
  input  logic download_win,  // matched download window
  input  logic xfer_active,   // any upload/download window open
  output logic upload_req,
  output logic dirty
);

  logic       cnt_prev_r;
  logic       up_prev_r;
  logic       dn_prev_r;
  logic       dirty_r;
  logic       pending_r;
  logic [7:0] count_r;
  logic       req_r;

  logic tick_s;
  logic up_end_s;
  logic dn_end_s;
  logic fire_s;

  // Edge detects and request condition
  always_comb begin
    tick_s   = cnt_4ms & ~cnt_prev_r;
    up_end_s = up_prev_r & ~upload_win;
    dn_end_s = dn_prev_r & ~download_win;
    fire_s   = (count_r == TICKS) && dirty_r && !pending_r && !xfer_active;
  end

  // Dirty/pending/quiet-counter state and the one-cycle request pulse
  always_ff @(posedge clock_12) begin
    if (reset) begin
      cnt_prev_r <= 1'b0;
      up_prev_r  <= 1'b0;
      dn_prev_r  <= 1'b0;
      dirty_r    <= 1'b0;
      pending_r  <= 1'b0;
      count_r    <= 8'd0;
      req_r      <= 1'b0;
    end else begin
      cnt_prev_r <= cnt_4ms;
      up_prev_r  <= upload_win;
      dn_prev_r  <= download_win;
      req_r      <= fire_s;
      if (up_end_s) begin
        // the save has been taken: everything is clean again
        dirty_r   <= 1'b0;
        pending_r <= 1'b0;
        count_r   <= 8'd0;
      end else begin
        if (cpu_cmos_we && !download_win) begin
          dirty_r <= 1'b1;
        end else if (dn_end_s) begin
          // freshly restored contents match the saved file
          dirty_r <= 1'b0;
        end
        if (fire_s) begin
          pending_r <= 1'b1;
        end
        if (cpu_cmos_we) begin
          count_r <= 8'd0;
        end else if (tick_s && dirty_r && (count_r < TICKS)) begin
          count_r <= count_r + 8'd1;
        end
      end
    end
  end

  assign upload_req = req_r;
  assign dirty      = dirty_r;

endmodule

// File: rtl/cmos_nvram_bridge.sv
// Bridges the 1Kx4 CMOS RAM to the HPS ioctl channel: nibble read-out on
// upload, nibble restore on download, and autosave requests after CPU writes.
module cmos_nvram_bridge
  import williams2_pkg::*;
#(
  parameter logic [15:0] NV_INDEX       = NV_INDEX_DEF,
  parameter int          RAM_DEPTH      = 1024,
  parameter logic [7:0]  AUTOSAVE_TICKS = 8'd250
) (
  input  logic         clock_12,
  input  logic         reset,
  input  logic         ioctl_upload,
  input  logic         ioctl_download,
  input  logic [15:0]  ioctl_index,
  input  logic [24:0]  ioctl_addr,
  input  logic         ioctl_rd,
  input  logic         ioctl_wr,
  input  logic [7:0]   ioctl_dout,
  output logic [7:0]   ioctl_din,
  output logic         ioctl_upload_req,
  output logic [9:0]   ram_addr,
  output logic [3:0]   ram_wdata,
  output logic         ram_we,
  input  logic [3:0]   ram_rdata,
  input  logic         cpu_cmos_we,
  input  logic         cnt_4ms,
  output logic         busy
);

  localparam logic [24:0] DEPTH_L = 25'(RAM_DEPTH);

  nv_state_t                state_r;
  logic [CMOS_AW-1:0]       ram_addr_r;
  logic [CMOS_DW-1:0]       ram_wdata_r;
  logic                     in_range_r;
  logic [7:0]               din_r;

  logic       match_s;
  logic [7:0] rd_data_s;
  logic       dirty_s;
  logic       spare_unused_s;

  // upper download nibble and the dirty flag have no consumer here
  assign spare_unused_s = ^{ioctl_dout[7:4], dirty_s};

  // Index match and the byte returned for the current read
  always_comb begin
    match_s = (ioctl_index == NV_INDEX);
    if (in_range_r) begin
      rd_data_s = {4'h0, ram_rdata};
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Transfer FSM: capture address/data on an accepted strobe, then sequence
  always_ff @(posedge clock_12) begin
    if (reset) begin
      state_r     <= IDLE;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      in_range_r  <= 1'b0;
      din_r       <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          // upload is checked first so a simultaneous wr is dropped
          if (match_s && ioctl_rd && ioctl_upload) begin
            state_r    <= RD_ADDR;
            ram_addr_r <= ioctl_addr[CMOS_AW-1:0];
            in_range_r <= nv_in_range(ioctl_addr, DEPTH_L);
          end else if (match_s && ioctl_wr && ioctl_download) begin
            state_r     <= WR;
            ram_addr_r  <= ioctl_addr[CMOS_AW-1:0];
            ram_wdata_r <= ioctl_dout[CMOS_DW-1:0];
            in_range_r  <= nv_in_range(ioctl_addr, DEPTH_L);
          end else begin
            state_r <= IDLE;
          end
        end
        RD_ADDR: state_r <= RD_DATA;
        RD_DATA: begin
          din_r   <= rd_data_s;
          state_r <= IDLE;
        end
        WR:      state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Outputs: read data is forwarded in RD_DATA so it is valid two cycles after
  // the strobe and then held from din_r; ram_we is gated by reset so an
  // interrupted write never reaches the RAM.
  always_comb begin
    if (state_r == RD_DATA) begin
      ioctl_din = rd_data_s;
    end else begin
      ioctl_din = din_r;
    end
    ram_we = (state_r == WR) && in_range_r && !reset;
    busy   = (state_r != IDLE) || (match_s && (ioctl_upload || ioctl_download));
  end

  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;

  nv_autosave_timer #(
    .TICKS(AUTOSAVE_TICKS)
  ) u_autosave (
    .clock_12     (clock_12),
    .reset        (reset),
    .cnt_4ms      (cnt_4ms),
    .cpu_cmos_we  (cpu_cmos_we),
    .upload_win   (match_s && ioctl_upload),
    .download_win (match_s && ioctl_download),
    .xfer_active  (ioctl_upload || ioctl_download),
    .upload_req   (ioctl_upload_req),
    .dirty        (dirty_s)
  );

endmodule

// File: tb/tb_cmos_nvram_bridge.sv
// Self-checking bench for cmos_nvram_bridge: directed and random ioctl
// transfers against a nibble-array model, plus autosave request counting.
module tb_cmos_nvram_bridge;

  localparam logic [15:0] IDX = 16'd4;

  logic        clock_12 = 1'b0;
  logic        reset;
  logic        ioctl_upload, ioctl_download;
  logic [15:0] ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd, ioctl_wr;
  logic [7:0]  ioctl_dout, ioctl_din;
  logic        ioctl_upload_req;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_wdata, ram_rdata;
  logic        ram_we, cpu_cmos_we, cnt_4ms, busy;

  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [3:0]  pre_data;
  logic [3:0]  mem     [0:1023];
  logic [3:0]  exp_mem [0:1023];

  int checks = 0;
  int errors = 0;
  int req_hi = 0;
  int exp_pulses = 0;
  logic [7:0] exp_din = 8'h00;
  bit m_dirty = 1'b0;
  bit m_pending = 1'b0;
  int m_edges = 0;

  always #5 clock_12 = ~clock_12;

  cmos_nvram_bridge #(
    .NV_INDEX(16'd4), .RAM_DEPTH(1024), .AUTOSAVE_TICKS(8'd3)
  ) dut (
    .clock_12(clock_12), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_upload_req(ioctl_upload_req),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .cpu_cmos_we(cpu_cmos_we),
    .cnt_4ms(cnt_4ms), .busy(busy)
  );

  // CMOS RAM second port: synchronous read, 1-cycle latency, bench preload
  always @(posedge clock_12) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Count cycles with the autosave request high
  always @(negedge clock_12) begin
    if (ioctl_upload_req) req_hi <= req_hi + 1;
  end

  task automatic cyc();
    @(posedge clock_12);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One ioctl transfer: strobe in cycle N, address in N+1, data in N+2
  task automatic do_op(input bit is_rd, input logic [15:0] idx,
                       input logic [24:0] addr, input logic [7:0] dout);
    bit match;
    bit inr;
    match = (idx == IDX);
    inr   = (addr < 25'd1024);
    ioctl_index = idx; ioctl_addr = addr; ioctl_dout = dout;
    ioctl_upload = is_rd; ioctl_download = !is_rd;
    ioctl_rd = is_rd; ioctl_wr = !is_rd;
    @(negedge clock_12);
    check("busy_win", 32'(busy), 32'(match));
    cyc();
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    @(negedge clock_12);
    check("busy_fsm", 32'(busy), 32'(match));
    check("ram_we", 32'(ram_we), 32'(!is_rd && match && inr));
    if (match && inr) check("ram_addr", 32'(ram_addr), 32'(addr[9:0]));
    if (!is_rd && match && inr) check("ram_wdata", 32'(ram_wdata), 32'(dout[3:0]));
    if (is_rd && match) exp_din = inr ? {4'h0, exp_mem[addr[9:0]]} : 8'h00;
    cyc();
    @(negedge clock_12);
    check("din", 32'(ioctl_din), 32'(exp_din));
    check("ram_we_off", 32'(ram_we), 32'd0);
    cyc();
    @(negedge clock_12);
    check("din_hold", 32'(ioctl_din), 32'(exp_din));
    ioctl_upload = 1'b0; ioctl_download = 1'b0;
    cyc();
    if (!is_rd && match && inr) exp_mem[addr[9:0]] = dout[3:0];
  endtask

  task automatic cmos_write();
    cpu_cmos_we = 1'b1; cyc();
    cpu_cmos_we = 1'b0; cyc();
    m_dirty = 1'b1; m_edges = 0;
  endtask

  // One cnt_4ms period; the model counts quiet edges since the last CPU write
  task automatic tick();
    cnt_4ms = 1'b1; cyc();
    cnt_4ms = 1'b0; cyc(); cyc(); cyc();
    if (m_dirty && m_edges < 3) m_edges++;
    if (m_dirty && m_edges == 3 && !m_pending) begin
      exp_pulses++;
      m_pending = 1'b1;
    end
  endtask

  task automatic upload_end();
    ioctl_index = IDX; ioctl_upload = 1'b1; cyc(); cyc();
    ioctl_upload = 1'b0; cyc(); cyc();
    m_dirty = 1'b0; m_pending = 1'b0; m_edges = 0;
  endtask

  initial begin
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_download = 1'b0;
    ioctl_index = 16'd0; ioctl_addr = 25'd0; ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    ioctl_dout = 8'h00; cpu_cmos_we = 1'b0; cnt_4ms = 1'b0;
    pre_we = 1'b0; pre_addr = 10'd0; pre_data = 4'h0;
    cyc();

    // preload CMOS with random nibbles, 0x123 = A
    for (int i = 0; i < 1024; i++) begin
      pre_we = 1'b1; pre_addr = 10'(i);
      pre_data = (i == 32'h123) ? 4'hA : 4'($urandom);
      exp_mem[i] = pre_data;
      cyc();
    end
    pre_we = 1'b0;
    cyc();
    reset = 1'b0;
    @(negedge clock_12);
    check("rst_din", 32'(ioctl_din), 32'h00);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_req", 32'(ioctl_upload_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cyc();

    // directed transfers
    do_op(1'b1, IDX, 25'h123, 8'h00);
    do_op(1'b0, IDX, 25'h3FF, 8'h5C);
    do_op(1'b1, IDX, 25'h400, 8'h00);
    do_op(1'b0, IDX, 25'h400, 8'hFF);
    do_op(1'b1, IDX, 25'h123, 8'h00);
    do_op(1'b1, 16'h0000, 25'h3FF, 8'h00);
    do_op(1'b0, 16'h0000, 25'h005, 8'h03);
    do_op(1'b1, IDX, 25'h3FF, 8'h00);

    // simultaneous rd and wr: the read proceeds, the write is dropped
    ioctl_index = IDX; ioctl_addr = 25'h005; ioctl_dout = 8'h0E;
    ioctl_upload = 1'b1; ioctl_download = 1'b1; ioctl_rd = 1'b1; ioctl_wr = 1'b1;
    cyc();
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    @(negedge clock_12);
    check("both_no_we", 32'(ram_we), 32'd0);
    cyc();
    exp_din = {4'h0, exp_mem[5]};
    @(negedge clock_12);
    check("both_din", 32'(ioctl_din), 32'(exp_din));
    ioctl_upload = 1'b0; ioctl_download = 1'b0;
    cyc(); cyc();

    // random transfers
    for (int n = 0; n < 60; n++) begin
      logic [15:0] idx;
      logic [24:0] addr;
      idx  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 15)) : IDX;
      addr = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(1024, 1279))
                                         : 25'($urandom_range(0, 1023));
      do_op(1'($urandom_range(0, 1)), idx, addr, 8'($urandom));
    end

    // autosave: quiet count restart, single pulse, pending, upload end
    cmos_write(); tick(); tick();
    check("as_early", 32'(req_hi), 32'(exp_pulses));
    cmos_write(); tick(); tick();
    check("as_restart", 32'(req_hi), 32'(exp_pulses));
    tick();
    check("as_pulse", 32'(req_hi), 32'd1);
    tick(); tick();
    check("as_pending", 32'(req_hi), 32'd1);
    upload_end(); tick(); tick(); tick();
    check("as_clean", 32'(req_hi), 32'd1);
    cmos_write(); tick(); tick(); tick();
    check("as_second", 32'(req_hi), 32'd2);
    upload_end();

    // download end marks contents clean
    cmos_write();
    ioctl_index = IDX; ioctl_download = 1'b1; cyc(); cyc();
    ioctl_download = 1'b0; cyc(); cyc();
    m_dirty = 1'b0;
    tick(); tick(); tick();
    check("as_dl_clean", 32'(req_hi), 32'(exp_pulses));

    // random autosave events
    for (int n = 0; n < 30; n++) begin
      int ev;
      ev = $urandom_range(0, 9);
      if (ev < 2) cmos_write();
      else if (ev == 2) upload_end();
      else tick();
      check("as_rand", 32'(req_hi), 32'(exp_pulses));
    end

    // reset during the WR cycle
    ioctl_index = IDX; ioctl_addr = 25'h010; ioctl_dout = 8'h07;
    ioctl_download = 1'b1; ioctl_wr = 1'b1;
    cyc();
    ioctl_wr = 1'b0; ioctl_download = 1'b0; reset = 1'b1;
    @(negedge clock_12);
    check("rstwr_we", 32'(ram_we), 32'd0);
    cyc();
    reset = 1'b0;
    exp_din = 8'h00;
    @(negedge clock_12);
    check("rstwr_din", 32'(ioctl_din), 32'h00);
    check("rstwr_addr", 32'(ram_addr), 32'd0);
    check("rstwr_wdata", 32'(ram_wdata), 32'd0);
    check("rstwr_we2", 32'(ram_we), 32'd0);
    check("rstwr_req", 32'(ioctl_upload_req), 32'd0);
    check("rstwr_busy", 32'(busy), 32'd0);
    check("rstwr_mem", 32'(mem[16]), 32'(exp_mem[16]));
    cyc();
    do_op(1'b1, IDX, 25'h010, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
